// File: rtl/count_wrap_tracker.sv
// Tracks a 4-bit up/down counter, extends it with a wrap epoch and emits wrap events.
// Define COUNT_WRAP_JUMP_ERR_EN to enable the jump_err pulse on illegal steps.
module count_wrap_tracker #(
    parameter int EPOCH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         cnt_in,
    input  logic               ld_in,
    output logic [EPOCH_W+3:0] ext_count,
    output logic [1:0]         dir,
    output logic               wrap_up,
    output logic               wrap_dn,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_dir,
    output logic [EPOCH_W-1:0] evt_epoch,
    output logic               evt_ovf,
    output logic               jump_err
);

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_HOLD = 2'b11
    } dir_t;

    dir_t               state;
    logic [3:0]         prev;
    logic               ld_q;
    logic [EPOCH_W-1:0] epoch;

    logic [3:0]         delta;
    logic               classify;
    logic               step_up;
    logic               step_dn;
    logic               up_wrap;
    logic               dn_wrap;
    logic               any_wrap;
    logic               evt_take;
    logic [EPOCH_W-1:0] epoch_nxt;

    // Steps are only meaningful once a first sample exists and no load is landing.
    assign delta    = cnt_in - prev;
    assign classify = (state != S_INIT) && !ld_q;
    assign step_up  = classify && (delta == 4'd1);
    assign step_dn  = classify && (delta == 4'd15);
    assign up_wrap  = step_up && (prev == 4'd15);
    assign dn_wrap  = step_dn && (prev == 4'd0);
    assign any_wrap = up_wrap || dn_wrap;
    assign evt_take = any_wrap && (!evt_valid || evt_ready);

`ifdef COUNT_WRAP_JUMP_ERR_EN
    logic is_jump;
    assign is_jump = classify && (delta != 4'd0) && !step_up && !step_dn;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        epoch_nxt = epoch;
        if (up_wrap)
            epoch_nxt = epoch + EPOCH_W'(1);
        else if (dn_wrap)
            epoch_nxt = epoch - EPOCH_W'(1);
    end

    assign ext_count = {epoch, prev};
    assign dir       = state;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            prev      <= 4'd0;
            ld_q      <= 1'b0;
            epoch     <= '0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
            evt_valid <= 1'b0;
            evt_dir   <= 1'b0;
            evt_epoch <= '0;
            evt_ovf   <= 1'b0;
            jump_err  <= 1'b0;
        end else begin
            prev    <= cnt_in;
            ld_q    <= ld_in;
            epoch   <= epoch_nxt;
            wrap_up <= up_wrap;
            wrap_dn <= dn_wrap;
`ifdef COUNT_WRAP_JUMP_ERR_EN
            jump_err <= is_jump;
`else
            jump_err <= 1'b0;
`endif
            if (step_up)
                state <= S_UP;
            else if (step_dn)
                state <= S_DOWN;
            else
                state <= S_HOLD;

            // A consume and a new wrap in the same cycle hand over without overflow.
            if (evt_take) begin
                evt_valid <= 1'b1;
                evt_dir   <= up_wrap;
                evt_epoch <= epoch_nxt;
            end else if (any_wrap) begin
                evt_ovf   <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Directed bench for count_wrap_tracker: extended-count model plus hand-computed checkpoints.
module tb_count_wrap_tracker;

    localparam int EPOCH_W = 4;
    localparam int EXT_MOD = 1 << (EPOCH_W + 4);
`ifdef COUNT_WRAP_JUMP_ERR_EN
    localparam int JE_EN = 1;
`else
    localparam int JE_EN = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         cnt_in = 4'd0;
    logic               ld_in = 1'b0;
    logic               evt_ready = 1'b1;
    logic [EPOCH_W+3:0] ext_count;
    logic [1:0]         dir;
    logic               wrap_up;
    logic               wrap_dn;
    logic               evt_valid;
    logic               evt_dir;
    logic [EPOCH_W-1:0] evt_epoch;
    logic               evt_ovf;
    logic               jump_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    count_wrap_tracker #(.EPOCH_W(EPOCH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .ld_in     (ld_in),
        .ext_count (ext_count),
        .dir       (dir),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_dir   (evt_dir),
        .evt_epoch (evt_epoch),
        .evt_ovf   (evt_ovf),
        .jump_err  (jump_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the extended count is one integer that moves by +-1 per legal step.
    int                 m_ext = 0;
    int                 m_dir = 0;
    bit                 m_started = 0;
    bit                 m_ldq = 0;
    bit                 m_wu = 0;
    bit                 m_wd = 0;
    bit                 m_je = 0;
    bit                 m_ovf = 0;
    logic [EPOCH_W:0]   m_q[$];

    always @(posedge clk) begin
        int c;
        int d;
        bit wrapped;
        logic [EPOCH_W:0] ev;
        if (rst) begin
            m_ext = 0; m_dir = 0; m_started = 0; m_ldq = 0;
            m_wu = 0; m_wd = 0; m_je = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            m_wu = 0; m_wd = 0; m_je = 0; wrapped = 0;
            c = int'(cnt_in);
            d = (c - (m_ext % 16) + 16) % 16;
            if (!m_started) begin
                m_started = 1;
                m_dir = 3;
                m_ext = m_ext - (m_ext % 16) + c;
            end else if (m_ldq || !(d == 0 || d == 1 || d == 15)) begin
                m_dir = 3;
                m_ext = m_ext - (m_ext % 16) + c;
                if (!m_ldq) m_je = (JE_EN != 0);
            end else if (d == 0) begin
                m_dir = 3;
            end else if (d == 1) begin
                m_dir = 1;
                m_ext = (m_ext + 1) % EXT_MOD;
                if (c == 0) begin m_wu = 1; wrapped = 1; end
            end else begin
                m_dir = 2;
                m_ext = (m_ext + EXT_MOD - 1) % EXT_MOD;
                if (c == 15) begin m_wd = 1; wrapped = 1; end
            end
            if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
            if (wrapped) begin
                ev = {m_wu, EPOCH_W'(m_ext / 16)};
                if (m_q.size() == 0) m_q.push_back(ev);
                else m_ovf = 1;
            end
            m_ldq = ld_in;
        end
    end

    always @(negedge clk) begin
        logic [EPOCH_W:0] head;
        if (chk_en) begin
            check("m_ext_count", int'(ext_count), m_ext);
            check("m_dir", int'(dir), m_dir);
            check("m_wrap_up", int'(wrap_up), int'(m_wu));
            check("m_wrap_dn", int'(wrap_dn), int'(m_wd));
            check("m_jump_err", int'(jump_err), int'(m_je));
            check("m_evt_valid", int'(evt_valid), int'(m_q.size() != 0));
            check("m_evt_ovf", int'(evt_ovf), int'(m_ovf));
            if (m_q.size() != 0) begin
                head = m_q[0];
                check("m_evt_dir", int'(evt_dir), int'(head[EPOCH_W]));
                check("m_evt_epoch", int'(evt_epoch), int'(head[EPOCH_W-1:0]));
            end
        end
    end

    // Drive one sample; returns at the following negedge with its result visible.
    task automatic cyc(input int c, input bit l, input bit r);
        cnt_in    = 4'(c);
        ld_in     = l;
        evt_ready = r;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        cyc(0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 1);
        check("rst_ext", int'(ext_count), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_ovf", int'(evt_ovf), 0);
        check("rst_evt_dir", int'(evt_dir), 0);
        check("rst_evt_epoch", int'(evt_epoch), 0);
        check("rst_jump", int'(jump_err), 0);
        rst = 1'b0;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("t1_ext", int'(ext_count), 'h00);
        check("t1_dir", int'(dir), 3);
        check("t1_wrap", int'(wrap_up), 0);

        // Up-wrap with ready
        cyc(0, 1, 1);
        cyc(13, 0, 1);
        check("t2_reload_ext", int'(ext_count), 'h0D);
        cyc(14, 0, 1);
        cyc(15, 0, 1);
        cyc(0, 0, 1);
        check("t2_wrap_up", int'(wrap_up), 1);
        check("t2_ext", int'(ext_count), 'h10);
        check("t2_valid", int'(evt_valid), 1);
        check("t2_evt_dir", int'(evt_dir), 1);
        check("t2_evt_epoch", int'(evt_epoch), 1);
        cyc(1, 0, 1);
        check("t2_valid_drop", int'(evt_valid), 0);
        check("t2_ext_after", int'(ext_count), 'h11);

        // Down-wrap, then consume and new wrap in the same cycle
        cyc(0, 0, 1);
        cyc(15, 0, 0);
        check("t3_wrap_dn", int'(wrap_dn), 1);
        check("t3_ext_0f", int'(ext_count), 'h0F);
        check("t3_evt_dir", int'(evt_dir), 0);
        check("t3_evt_epoch", int'(evt_epoch), 0);
        cyc(0, 0, 1);
        check("t3_handover_valid", int'(evt_valid), 1);
        check("t3_handover_dir", int'(evt_dir), 1);
        check("t3_handover_epoch", int'(evt_epoch), 1);
        check("t3_handover_ovf", int'(evt_ovf), 0);
        cyc(15, 0, 1);
        cyc(14, 0, 1);
        check("t3_ext", int'(ext_count), 'h0E);
        check("t3_dir", int'(dir), 2);

        // Reload vs illegal jump
        cyc(14, 1, 1);
        cyc(3, 0, 1);
        cyc(3, 1, 1);
        cyc(6, 0, 1);
        check("t4_load_jump", int'(jump_err), 0);
        check("t4_load_ext", int'(ext_count), 'h06);
        check("t4_load_dir", int'(dir), 3);
        cyc(6, 1, 1);
        cyc(3, 0, 1);
        cyc(9, 0, 1);
        check("t4_jump_err", int'(jump_err), JE_EN);
        check("t4_jump_ext", int'(ext_count), 'h09);

        // Overflow with ready low
        for (int c = 10; c <= 15; c++) cyc(c, 0, 0);
        cyc(0, 0, 0);
        check("t5_first_epoch", int'(evt_epoch), 1);
        check("t5_first_ovf", int'(evt_ovf), 0);
        for (int c = 1; c <= 15; c++) cyc(c, 0, 0);
        cyc(0, 0, 0);
        check("t5_ext", int'(ext_count), 'h20);
        check("t5_held_epoch", int'(evt_epoch), 1);
        check("t5_ovf", int'(evt_ovf), 1);
        cyc(0, 0, 1);
        check("t5_drained", int'(evt_valid), 0);
        check("t5_ovf_sticky", int'(evt_ovf), 1);

        // Reset mid-count with an event pending
        cyc(15, 0, 0);
        cyc(0, 0, 0);
        for (int c = 1; c <= 7; c++) cyc(c, 0, 0);
        check("t6_pre_valid", int'(evt_valid), 1);
        check("t6_pre_ext", int'(ext_count), 'h27);
        rst = 1'b1;
        cyc(7, 0, 0);
        check("t6_rst_ext", int'(ext_count), 0);
        check("t6_rst_dir", int'(dir), 0);
        check("t6_rst_valid", int'(evt_valid), 0);
        check("t6_rst_ovf", int'(evt_ovf), 0);
        rst = 1'b0;
        cyc(7, 0, 0);
        check("t6_capture_ext", int'(ext_count), 'h07);
        check("t6_capture_dir", int'(dir), 3);
        check("t6_capture_jump", int'(jump_err), 0);

        // Epoch boundaries
        for (int c = 6; c >= 0; c--) cyc(c, 0, 1);
        cyc(15, 0, 1);
        check("ep_dn_ext", int'(ext_count), 'hFF);
        check("ep_dn_epoch", int'(evt_epoch), (1 << EPOCH_W) - 1);
        cyc(0, 0, 1);
        check("ep_up_ext", int'(ext_count), 'h00);
        check("ep_up_epoch", int'(evt_epoch), 0);
        check("ep_up_dir", int'(evt_dir), 1);

        cyc(0, 0, 1);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
